// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register for the multithreaded core, with a 2-entry skid buffer and thread-selective flush.
// Latency: 1 cycle from accept to out_valid when the stage is empty or draining; 1 bundle/cycle while out_ready=1.
// Backpressure: in_ready comes from registered skid state only; the skid entry absorbs the one bundle in flight on a stall.
// Optional: define IDEX_STALL_CNT_EN to count back-pressure cycles on stall_cnt (tied to 0 otherwise).
module idex_skid_stage #(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int INSTMEM_LOG2_DEEP      = 8,
  parameter int THREAD_ID_W            = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              wreg_en_i,
  input  logic                              wmem_en_i,
  input  logic                              alu_src_i,
  input  logic                              mem_to_reg_i,
  input  logic [PROC_DATA_WIDTH-1:0]        r1_i,
  input  logic [PROC_DATA_WIDTH-1:0]        r2_i,
  input  logic [PROC_DATA_WIDTH-1:0]        imm_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] wreg_i,
  input  logic [2:0]                        func3_i,
  input  logic                              func7_i,
  input  logic [THREAD_ID_W-1:0]            thread_id_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0]      pc_i,
  input  logic                              flush_en,
  input  logic [THREAD_ID_W-1:0]            flush_thread,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              wreg_en_o,
  output logic                              wmem_en_o,
  output logic                              alu_src_o,
  output logic                              mem_to_reg_o,
  output logic [PROC_DATA_WIDTH-1:0]        r1_o,
  output logic [PROC_DATA_WIDTH-1:0]        r2_o,
  output logic [PROC_DATA_WIDTH-1:0]        imm_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] wreg_o,
  output logic [2:0]                        func3_o,
  output logic                              func7_o,
  output logic [THREAD_ID_W-1:0]            thread_id_o,
  output logic [INSTMEM_LOG2_DEEP-1:0]      pc_o,
  output logic [15:0]                       stall_cnt
);

  // One instruction bundle as it travels from decode to EX.
  typedef struct packed {
    logic                              wreg_en;
    logic                              wmem_en;
    logic                              alu_src;
    logic                              mem_to_reg;
    logic [PROC_DATA_WIDTH-1:0]        r1;
    logic [PROC_DATA_WIDTH-1:0]        r2;
    logic [PROC_DATA_WIDTH-1:0]        imm;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] wreg;
    logic [2:0]                        func3;
    logic                              func7;
    logic [THREAD_ID_W-1:0]            thread_id;
    logic [INSTMEM_LOG2_DEEP-1:0]      pc;
  } bundle_t;

  bundle_t in_b;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    main_v, main_v_d;
  logic    skid_v, skid_v_d;

  logic accept;
  logic kill_main, kill_skid, kill_in;
  logic mv, sv, iv;
  logic drain;

  // Gather the decode-side fields into one bundle.
  always_comb begin
    in_b            = '0;
    in_b.wreg_en    = wreg_en_i;
    in_b.wmem_en    = wmem_en_i;
    in_b.alu_src    = alu_src_i;
    in_b.mem_to_reg = mem_to_reg_i;
    in_b.r1         = r1_i;
    in_b.r2         = r2_i;
    in_b.imm        = imm_i;
    in_b.wreg       = wreg_i;
    in_b.func3      = func3_i;
    in_b.func7      = func7_i;
    in_b.thread_id  = thread_id_i;
    in_b.pc         = pc_i;
  end

  // Ready only from registered state: a full skid entry is the sole reason to refuse.
  assign in_ready = !skid_v && !RST;
  assign accept   = in_valid && in_ready;

  // Flush masking comes first; a killed incoming bundle still completes its handshake.
  always_comb begin
    kill_main = flush_en && (main_q.thread_id == flush_thread);
    kill_skid = flush_en && (skid_q.thread_id == flush_thread);
    kill_in   = flush_en && (thread_id_i == flush_thread);
    mv        = main_v && !kill_main;
    sv        = skid_v && !kill_skid;
    iv        = accept && !kill_in;
    drain     = mv && out_ready;
  end

  // Transfer: skid always refills main before any newer bundle, preserving order.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = mv;
    skid_v_d = sv;
    if (!mv || drain) begin
      if (sv) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = iv;
        if (iv) begin
          skid_d = in_b;
        end
      end else begin
        main_v_d = iv;
        skid_v_d = 1'b0;
        if (iv) begin
          main_d = in_b;
        end
      end
    end else if (iv) begin
      // Main is stalled; in_ready guaranteed the skid slot is free.
      skid_d   = in_b;
      skid_v_d = 1'b1;
    end
  end

  // Entry registers; reset discards both entries and zeroes the visible fields.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v <= main_v_d;
      skid_v <= skid_v_d;
    end
  end

  // Outputs come straight from the main entry; write enables are masked on bubbles.
  always_comb begin
    out_valid    = main_v;
    wreg_en_o    = main_q.wreg_en && main_v;
    wmem_en_o    = main_q.wmem_en && main_v;
    alu_src_o    = main_q.alu_src;
    mem_to_reg_o = main_q.mem_to_reg;
    r1_o         = main_q.r1;
    r2_o         = main_q.r2;
    imm_o        = main_q.imm;
    wreg_o       = main_q.wreg;
    func3_o      = main_q.func3;
    func7_o      = main_q.func7;
    thread_id_o  = main_q.thread_id;
    pc_o         = main_q.pc;
  end

`ifdef IDEX_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count cycles where EX refuses a valid bundle; saturates, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= 16'd0;
    end else if (main_v && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_idex_skid_stage.sv
// Directed bench for idex_skid_stage: stimulus pushes expected bundles, a monitor pops them on each EX handshake.
// Latency and ordering are checked by the monitor; state checks (ready, bubbles, flush, reset) inline.
// Stall counter checks follow IDEX_STALL_CNT_EN.
module tb_idex_skid_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic        wreg_en_i, wmem_en_i, alu_src_i, mem_to_reg_i;
  logic [15:0] r1_i, r2_i, imm_i;
  logic [4:0]  wreg_i;
  logic [2:0]  func3_i;
  logic        func7_i;
  logic [1:0]  thread_id_i;
  logic [7:0]  pc_i;
  logic        flush_en;
  logic [1:0]  flush_thread;
  logic        out_valid;
  logic        out_ready;
  logic        wreg_en_o, wmem_en_o, alu_src_o, mem_to_reg_o;
  logic [15:0] r1_o, r2_o, imm_o;
  logic [4:0]  wreg_o;
  logic [2:0]  func3_o;
  logic        func7_o;
  logic [1:0]  thread_id_o;
  logic [7:0]  pc_o;
  logic [15:0] stall_cnt;

  idex_skid_stage dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .wreg_en_i(wreg_en_i), .wmem_en_i(wmem_en_i), .alu_src_i(alu_src_i), .mem_to_reg_i(mem_to_reg_i),
    .r1_i(r1_i), .r2_i(r2_i), .imm_i(imm_i), .wreg_i(wreg_i),
    .func3_i(func3_i), .func7_i(func7_i), .thread_id_i(thread_id_i), .pc_i(pc_i),
    .flush_en(flush_en), .flush_thread(flush_thread),
    .out_valid(out_valid), .out_ready(out_ready),
    .wreg_en_o(wreg_en_o), .wmem_en_o(wmem_en_o), .alu_src_o(alu_src_o), .mem_to_reg_o(mem_to_reg_o),
    .r1_o(r1_o), .r2_o(r2_o), .imm_o(imm_o), .wreg_o(wreg_o),
    .func3_o(func3_o), .func7_o(func7_o), .thread_id_o(thread_id_o), .pc_o(pc_o),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] r1;
    logic [1:0]  tid;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   done    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic set_in(input bit v, input logic [15:0] r1, input logic [1:0] tid, input bit we);
    in_valid     = v;
    r1_i         = r1;
    r2_i         = ~r1;
    imm_i        = {r1[7:0], r1[15:8]};
    pc_i         = r1[7:0];
    wreg_i       = r1[4:0];
    func3_i      = r1[2:0];
    func7_i      = r1[0];
    alu_src_i    = 1'b0;
    mem_to_reg_i = 1'b0;
    thread_id_i  = tid;
    wreg_en_i    = we;
    wmem_en_i    = we;
  endtask

  task automatic push(input logic [15:0] r1, input logic [1:0] tid, input bit we);
    exp_t e;
    e.r1 = r1; e.tid = tid; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  // Monitor: every bundle EX takes must be the oldest one still expected.
  always @(negedge CLK) begin
    if (!done && !RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_bundle: got r1=0x%0h tid=%0d, expected none", r1_o, thread_id_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_r1",  {16'd0, r1_o},  {16'd0, e.r1});
        check("sb_r2",  {16'd0, r2_o},  {16'd0, ~e.r1});
        check("sb_imm", {16'd0, imm_o}, {16'd0, e.r1[7:0], e.r1[15:8]});
        check("sb_pc",  {24'd0, pc_o},  {24'd0, e.r1[7:0]});
        check("sb_tid", {30'd0, thread_id_o}, {30'd0, e.tid});
        check("sb_wen", {31'd0, wreg_en_o},   {31'd0, e.we});
      end
    end
  end

  initial begin
    logic [15:0] exp_stall;
    RST = 1'b1; out_ready = 1'b1; flush_en = 1'b0; flush_thread = 2'd0;
    set_in(1'b1, 16'h0055, 2'd0, 1'b1);

    // Reset: bundles offered during reset are refused, outputs are zero.
    tick();
    samp();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_r1_o",      {16'd0, r1_o},      32'd0);
    check("rst_wreg_en_o", {31'd0, wreg_en_o}, 32'd0);
    check("rst_tid_o",     {30'd0, thread_id_o}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    tick();
    samp();
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    RST = 1'b0;
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    samp();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Streaming: four back-to-back bundles, output one cycle behind each accept.
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 16'(k + 1), 2'd0, 1'b1);
      push(16'(k + 1), 2'd0, 1'b1);
      samp();
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      check("stream_out_valid", {31'd0, out_valid}, (k == 0) ? 32'd0 : 32'd1);
      tick();
    end
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    samp();
    check("stream_last_valid", {31'd0, out_valid}, 32'd1);
    tick();
    samp();
    check("stream_empty", {31'd0, out_valid}, 32'd0);
    tick();

    // Back-pressure: A held in main, B parked in skid, then both leave in order.
    out_ready = 1'b0;
    set_in(1'b1, 16'h00AA, 2'd0, 1'b0);
    push(16'h00AA, 2'd0, 1'b0);
    tick();
    set_in(1'b1, 16'h00BB, 2'd0, 1'b0);
    push(16'h00BB, 2'd0, 1'b0);
    samp();
    check("bp_ready_skid_free", {31'd0, in_ready}, 32'd1);
    tick();
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    samp();
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_A",    {16'd0, r1_o},      32'h00AA);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b1;
    samp();
    tick();
    samp();
    check("bp_B_in_main",  {16'd0, r1_o},     32'h00BB);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    samp();
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    tick();

    // Thread flush: main (thread 1) killed, skid (thread 2) promoted, incoming thread 1 never seen.
    out_ready = 1'b0;
    set_in(1'b1, 16'h0111, 2'd1, 1'b0);
    tick();
    set_in(1'b1, 16'h0222, 2'd2, 1'b0);
    push(16'h0222, 2'd2, 1'b0);
    tick();
    set_in(1'b1, 16'h0333, 2'd1, 1'b0);
    flush_en = 1'b1; flush_thread = 2'd1;
    samp();
    check("fl_full_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush_en = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    samp();
    check("fl_out_valid", {31'd0, out_valid},   32'd1);
    check("fl_r1_o",      {16'd0, r1_o},        32'h0222);
    check("fl_tid_o",     {30'd0, thread_id_o}, 32'd2);
    check("fl_skid_empty", {31'd0, in_ready},   32'd1);
    tick();

    // Killed incoming bundle completes the handshake but is never stored.
    set_in(1'b1, 16'h0999, 2'd3, 1'b1);
    flush_en = 1'b1; flush_thread = 2'd3;
    samp();
    check("kill_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush_en = 1'b0;
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    samp();
    check("kill_not_stored", {31'd0, out_valid}, 32'd0);
    tick();

    // Bubble safety: a flushed stalled main must drop its write enables.
    out_ready = 1'b0;
    set_in(1'b1, 16'h0444, 2'd1, 1'b1);
    tick();
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    flush_en = 1'b1; flush_thread = 2'd1;
    samp();
    check("bub_pre_valid", {31'd0, out_valid}, 32'd1);
    check("bub_pre_wreg",  {31'd0, wreg_en_o}, 32'd1);
    check("bub_pre_wmem",  {31'd0, wmem_en_o}, 32'd1);
    tick();
    flush_en = 1'b0;
    samp();
    check("bub_valid",   {31'd0, out_valid}, 32'd0);
    check("bub_wreg",    {31'd0, wreg_en_o}, 32'd0);
    check("bub_wmem",    {31'd0, wmem_en_o}, 32'd0);
    check("bub_r1_hold", {16'd0, r1_o},      32'h0444);
    tick();

    // Reset mid-operation discards main and skid with no drain.
    set_in(1'b1, 16'h0666, 2'd0, 1'b1);
    tick();
    set_in(1'b1, 16'h0777, 2'd0, 1'b1);
    tick();
    RST = 1'b1;
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    samp();
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    RST = 1'b0;
    samp();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_wreg",  {31'd0, wreg_en_o}, 32'd0);
    check("mid_rst_ready_back", {31'd0, in_ready}, 32'd1);
    check("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
    tick();

    // Stall counter: five refused cycles, then saturation.
    set_in(1'b1, 16'h0555, 2'd0, 1'b0);
    push(16'h0555, 2'd0, 1'b0);
    tick();
    set_in(1'b0, 16'h0000, 2'd0, 1'b0);
    repeat (5) tick();
    samp();
`ifdef IDEX_STALL_CNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    check("stall_cnt_5", {16'd0, stall_cnt}, {16'd0, exp_stall});
`ifdef IDEX_STALL_CNT_EN
    force dut.stall_q = 16'hFFFE;
    #1;
    release dut.stall_q;
    repeat (3) tick();
    samp();
    check("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif
    tick();
    out_ready = 1'b1;
    samp();
    tick();
    samp();
    check("stall_drained", {31'd0, out_valid}, 32'd0);
    tick();

    check("sb_all_consumed", exp_q.size(), 32'd0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
